// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: handshaked pipeline stage register with a 2-entry skid buffer.
//
// Holds up to two payloads: the main register (drives o_data) and a skid register
// that catches the one extra beat accepted in the cycle downstream stalls. Because
// o_ready is registered, a downstream stall reaches upstream one cycle later.
// Every output is driven straight from a flop.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_flush      synchronous squash of all held entries
//   i_valid      upstream payload valid
//   o_ready      stage can accept this cycle
//   i_data       upstream payload
//   o_valid      o_data holds a live entry
//   i_ready      downstream accepts this cycle
//   o_data       payload of the oldest held entry (BUBBLE_VAL when not valid)
//   i_cnt_clr    synchronous clear of o_stall_cnt
//   o_stall_cnt  saturating count of cycles with o_valid=1 and i_ready=0
module pipe_stage_skid #(
    parameter int unsigned       DATA_W     = 128,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty,
        StBusy,
        StFull
    } state_e;

    state_e            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_valid;
    logic              r_ready;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_accept;
    logic w_drain;
    logic w_stall;
    logic w_cnt_max;

    assign w_accept  = i_valid & r_ready;
    assign w_drain   = r_valid & i_ready;
    assign w_stall   = r_valid & ~i_ready;
    assign w_cnt_max = (r_stall_cnt == {CNT_W{1'b1}});

    // State, storage and registered handshake outputs. A drain in the flush cycle
    // needs no action here: downstream already sampled o_data during that cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StEmpty;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else if (i_flush) begin
            r_state <= StEmpty;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    // Also the first cycle after reset, where o_ready rises.
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_state <= StBusy;
                        r_main  <= i_data;
                        r_valid <= 1'b1;
                    end
                end
                StBusy: begin
                    if (w_accept && w_drain) begin
                        r_main <= i_data;
                    end else if (w_accept) begin
                        // Downstream stalled this cycle: park the new beat in the skid.
                        r_state <= StFull;
                        r_skid  <= i_data;
                        r_ready <= 1'b0;
                    end else if (w_drain) begin
                        r_state <= StEmpty;
                        r_main  <= BUBBLE_VAL;
                        r_valid <= 1'b0;
                    end
                end
                StFull: begin
                    if (w_drain) begin
                        r_state <= StBusy;
                        r_main  <= r_skid;
                        r_skid  <= BUBBLE_VAL;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StEmpty;
                    r_main  <= BUBBLE_VAL;
                    r_skid  <= BUBBLE_VAL;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stall counter: clear wins over increment, saturates instead of wrapping,
    // and is deliberately untouched by flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !w_cnt_max) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_valid;
    assign o_data      = r_main;
    assign o_stall_cnt = r_stall_cnt;

    a_full_not_ready : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_state == StFull) |-> !r_ready);
    a_no_accept_full : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_state == StFull) |-> !w_accept);
    a_bubble_idle : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !r_valid |-> (r_main == BUBBLE_VAL));

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          ds_ready;
    logic [DW-1:0] out_data;
    logic          cnt_clr;
    logic [CW-1:0] stall_cnt;

    pipe_stage_skid #(
        .DATA_W    (DW),
        .BUBBLE_VAL('0),
        .CNT_W     (CW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_valid    (in_valid),
        .o_ready    (out_ready),
        .i_data     (in_data),
        .o_valid    (out_valid),
        .i_ready    (ds_ready),
        .o_data     (out_data),
        .i_cnt_clr  (cnt_clr),
        .o_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    typedef struct {
        logic          fl;
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          c;
        logic          ev;
        logic          er;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic v, input logic [DW-1:0] d,
                                input logic r, input logic c, input logic ev,
                                input logic er, input logic [DW-1:0] ed, input int ec);
        vec_t t;
        t.fl = fl; t.v = v; t.d = d; t.r = r; t.c = c;
        t.ev = ev; t.er = er; t.ed = ed; t.ec = CW'(ec);
        return t;
    endfunction

    // Inputs are driven 1 after a rising edge; outputs checked 1 after the next.
    task automatic step(input vec_t t, input int idx);
        flush    = t.fl;
        in_valid = t.v;
        in_data  = t.d;
        ds_ready = t.r;
        cnt_clr  = t.c;
        @(posedge clk);
        #1;
        chk("o_valid", idx, DW'(out_valid), DW'(t.ev));
        chk("o_ready", idx, DW'(out_ready), DW'(t.er));
        chk("o_data", idx, out_data, t.ed);
        chk("o_stall_cnt", idx, DW'(stall_cnt), DW'(t.ec));
    endtask

    // Scoreboard: beats pushed on accept, popped and compared on drain, mid-cycle.
    logic [DW-1:0] sb[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && ds_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: got 0x%0h, expected no beat", out_data);
                end else begin
                    chk("sb_order", 0, out_data, sb.pop_front());
                end
            end
            if (flush) sb.delete();
            else if (in_valid && out_ready) sb.push_back(in_data);
            if (!out_valid) chk("sb_bubble", 0, out_data, '0);
        end
    end

    vec_t tbl[18];

    initial begin
        // flush, valid, data, ready, clr -> valid, ready, data, cnt
        tbl[0]  = mk(0, 0, 'h00, 1, 0, 0, 1, 'h00, 0);  // first edge after reset
        tbl[1]  = mk(0, 1, 'h11, 1, 0, 1, 1, 'h11, 0);  // streaming
        tbl[2]  = mk(0, 1, 'h22, 1, 0, 1, 1, 'h22, 0);
        tbl[3]  = mk(0, 1, 'h33, 1, 0, 1, 1, 'h33, 0);
        tbl[4]  = mk(0, 0, 'h00, 1, 0, 0, 1, 'h00, 0);
        tbl[5]  = mk(0, 1, 'hA1, 1, 0, 1, 1, 'hA1, 0);  // backpressure
        tbl[6]  = mk(0, 1, 'hB2, 0, 0, 1, 0, 'hA1, 1);  // -> FULL
        tbl[7]  = mk(0, 1, 'hC3, 0, 0, 1, 0, 'hA1, 2);
        tbl[8]  = mk(0, 1, 'hC3, 0, 0, 1, 0, 'hA1, 3);
        tbl[9]  = mk(0, 1, 'hC3, 1, 0, 1, 1, 'hB2, 3);
        tbl[10] = mk(0, 1, 'hC3, 1, 0, 1, 1, 'hC3, 3);
        tbl[11] = mk(0, 0, 'h00, 1, 0, 0, 1, 'h00, 3);
        tbl[12] = mk(0, 1, 'hE1, 1, 0, 1, 1, 'hE1, 3);  // flush in FULL
        tbl[13] = mk(0, 1, 'hE2, 0, 0, 1, 0, 'hE1, 4);
        tbl[14] = mk(1, 1, 'hDD, 1, 0, 0, 1, 'h00, 4);
        tbl[15] = mk(0, 0, 'h00, 1, 0, 0, 1, 'h00, 4);
        tbl[16] = mk(0, 1, 'h55, 1, 0, 1, 1, 'h55, 4);  // flush with drain in BUSY
        tbl[17] = mk(1, 0, 'h00, 1, 0, 0, 1, 'h00, 4);

        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 'h99;
        ds_ready = 1'b0;
        cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, DW'(out_valid), '0);
        chk("rst_ready", 0, DW'(out_ready), '0);
        chk("rst_data", 0, out_data, '0);
        chk("rst_cnt", 0, DW'(stall_cnt), '0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) step(tbl[i], i);

        // Saturation: one live beat held for 20 stall cycles, counter starts at 4.
        step(mk(0, 1, 'h66, 1, 0, 1, 1, 'h66, 4), 100);
        for (int i = 0; i < 20; i++) begin
            int e;
            e = (4 + i + 1 > 15) ? 15 : 4 + i + 1;
            step(mk(0, 0, 'h00, 0, 0, 1, 1, 'h66, e), 101 + i);
        end
        step(mk(0, 0, 'h00, 0, 1, 1, 1, 'h66, 0), 130);  // clear beats increment
        step(mk(0, 0, 'h00, 0, 0, 1, 1, 'h66, 1), 131);
        step(mk(0, 0, 'h00, 1, 1, 0, 1, 'h00, 0), 132);

        // Asynchronous reset mid-cycle while FULL.
        step(mk(0, 1, 'hA5, 1, 0, 1, 1, 'hA5, 0), 200);
        step(mk(0, 1, 'hB6, 0, 0, 1, 0, 'hA5, 1), 201);
        in_data = 'hC7;
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_valid", 202, DW'(out_valid), '0);
        chk("arst_ready", 202, DW'(out_ready), '0);
        chk("arst_data", 202, out_data, '0);
        chk("arst_cnt", 202, DW'(stall_cnt), '0);
        @(posedge clk);
        #1;
        chk("arst_hold_ready", 203, DW'(out_ready), '0);
        rst_n = 1'b1;
        step(mk(0, 1, 'h70, 1, 0, 0, 1, 'h00, 0), 204);  // o_ready low: 0x70 not taken
        step(mk(0, 1, 'h71, 1, 0, 1, 1, 'h71, 0), 205);
        step(mk(0, 1, 'h72, 1, 0, 1, 1, 'h72, 0), 206);
        step(mk(0, 1, 'h73, 1, 0, 1, 1, 'h73, 0), 207);
        step(mk(0, 0, 'h00, 1, 0, 0, 1, 'h00, 0), 208);

        @(posedge clk);
        #1;
        chk("sb_empty", 300, DW'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
